// File: rtl/pcie_us_cq_cc_responder.sv
// Completer for single-dword memory reads/writes against a 16 x 32-bit register file.
// Accepts requests on the CQ stream and answers reads with a two-beat CC completion.
module pcie_us_cq_cc_responder #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 32,
  parameter int unsigned CQ_USER_WIDTH = 88,
  parameter int unsigned CC_USER_WIDTH = 33
) (
  input  logic                     user_clk,
  input  logic                     user_reset,

  input  logic [DATA_WIDTH-1:0]    s_axis_cq_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
  input  logic                     s_axis_cq_tlast,
  input  logic [CQ_USER_WIDTH-1:0] s_axis_cq_tuser,
  input  logic                     s_axis_cq_tvalid,
  output logic                     s_axis_cq_tready,

  output logic [DATA_WIDTH-1:0]    m_axis_cc_tdata,
  output logic [KEEP_WIDTH-1:0]    m_axis_cc_tkeep,
  output logic                     m_axis_cc_tlast,
  output logic [CC_USER_WIDTH-1:0] m_axis_cc_tuser,
  output logic                     m_axis_cc_tvalid,
  input  logic                     m_axis_cc_tready,

  output logic [1:0]               pcie_cq_np_req,
  input  logic [7:0]               cfg_bus_number,
  output logic                     stat_err_req
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr1,
    StWdata,
    StDrop,
    StCpl0,
    StCpl1
  } state_e;

  localparam logic [2:0] CplSc = 3'b000;
  localparam logic [2:0] CplUr = 3'b001;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_cpl_pend;
  logic        w_cpl_pend_nxt;
  logic [2:0]  r_status;
  logic [2:0]  w_status_nxt;
  logic [4:0]  r_addr;
  logic [3:0]  r_first_be;
  logic [15:0] r_req_id;
  logic [7:0]  r_tag;
  logic [7:0]  r_func;
  logic [2:0]  r_tc;
  logic [2:0]  r_attr;
  logic [31:0] r_rdata;
  logic [31:0] r_regs [16];

  logic        w_cq_hs;
  logic        w_cc_hs;
  logic        w_err;
  logic        w_enter_cpl0;
  logic [3:0]  w_req_type;
  logic [10:0] w_dw_count;
  logic        w_dw_one;
  logic        w_ur;
  logic [63:0] w_beat0;
  logic [63:0] w_beat1;
  logic        w_unused;

  assign w_unused = ^{s_axis_cq_tkeep, s_axis_cq_tuser[CQ_USER_WIDTH-1:4],
                      s_axis_cq_tdata[63], s_axis_cq_tdata[56:48], s_axis_cq_tdata[15]};

  assign s_axis_cq_tready = !user_reset &&
                            (r_state == StIdle || r_state == StHdr1 ||
                             r_state == StWdata || r_state == StDrop);
  assign m_axis_cc_tvalid = !user_reset && (r_state == StCpl0 || r_state == StCpl1);

  assign w_cq_hs    = s_axis_cq_tvalid && s_axis_cq_tready;
  assign w_cc_hs    = m_axis_cc_tvalid && m_axis_cc_tready;
  assign w_req_type = s_axis_cq_tdata[14:11];
  assign w_dw_count = s_axis_cq_tdata[10:0];
  assign w_dw_one   = (w_dw_count == 11'd1);

  always_comb begin
    w_state_nxt    = r_state;
    w_cpl_pend_nxt = r_cpl_pend;
    w_status_nxt   = r_status;
    w_err          = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_cq_hs) begin
          if (s_axis_cq_tlast) w_err = 1'b1;
          else                 w_state_nxt = StHdr1;
        end
      end
      StHdr1: begin
        if (w_cq_hs) begin
          if (w_req_type == 4'b0000) begin
            w_status_nxt   = w_dw_one ? CplSc : CplUr;
            w_err          = !w_dw_one;
            w_cpl_pend_nxt = 1'b1;
            w_state_nxt    = s_axis_cq_tlast ? StCpl0 : StDrop;
          end else if (w_req_type == 4'b0001 && w_dw_one && !s_axis_cq_tlast) begin
            w_state_nxt = StWdata;
          end else begin
            // Includes a write header carrying tlast: no data beat will follow.
            w_err          = 1'b1;
            w_cpl_pend_nxt = 1'b0;
            w_state_nxt    = s_axis_cq_tlast ? StIdle : StDrop;
          end
        end
      end
      StWdata: begin
        if (w_cq_hs) begin
          w_cpl_pend_nxt = 1'b0;
          w_state_nxt    = s_axis_cq_tlast ? StIdle : StDrop;
        end
      end
      StDrop: begin
        if (w_cq_hs && s_axis_cq_tlast) begin
          w_state_nxt = r_cpl_pend ? StCpl0 : StIdle;
        end
      end
      StCpl0: begin
        if (w_cc_hs) w_state_nxt = StCpl1;
      end
      StCpl1: begin
        if (w_cc_hs) begin
          w_cpl_pend_nxt = 1'b0;
          w_state_nxt    = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_enter_cpl0 = (w_state_nxt == StCpl0) && (r_state != StCpl0);

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_state    <= StIdle;
      r_cpl_pend <= 1'b0;
      r_status   <= CplSc;
      r_addr     <= '0;
      r_first_be <= '0;
      r_req_id   <= '0;
      r_tag      <= '0;
      r_func     <= '0;
      r_tc       <= '0;
      r_attr     <= '0;
      r_rdata    <= '0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cpl_pend <= w_cpl_pend_nxt;
      r_status   <= w_status_nxt;
      if (r_state == StIdle && w_cq_hs) begin
        r_addr     <= s_axis_cq_tdata[6:2];
        r_first_be <= s_axis_cq_tuser[3:0];
      end
      if (r_state == StHdr1 && w_cq_hs) begin
        r_req_id <= s_axis_cq_tdata[31:16];
        r_tag    <= s_axis_cq_tdata[39:32];
        r_func   <= s_axis_cq_tdata[47:40];
        r_tc     <= s_axis_cq_tdata[59:57];
        r_attr   <= s_axis_cq_tdata[62:60];
      end
      if (r_state == StWdata && w_cq_hs) begin
        for (int b = 0; b < 4; b++) begin
          if (r_first_be[b]) r_regs[r_addr[3:0]][8*b +: 8] <= s_axis_cq_tdata[8*b +: 8];
        end
      end
      if (w_enter_cpl0) r_rdata <= r_regs[r_addr[3:0]];
    end
  end

  assign w_ur = (r_status == CplUr);

  // Bit 47 is reserved, bit 46 is the poisoned flag.
  assign w_beat0 = {r_req_id, 1'b0, 1'b0, r_status, (w_ur ? 11'd0 : 11'd1), 3'b000,
                    13'd4, 6'b000000, 2'b00, 1'b0, r_addr, 2'b00};
  assign w_beat1 = {(w_ur ? 32'h0 : r_rdata), 1'b0, r_attr, r_tc, 1'b1, cfg_bus_number,
                    r_func, r_tag};

  always_comb begin
    m_axis_cc_tdata = '0;
    m_axis_cc_tkeep = '0;
    m_axis_cc_tlast = 1'b0;
    if (m_axis_cc_tvalid) begin
      if (r_state == StCpl0) begin
        m_axis_cc_tdata = w_beat0;
        m_axis_cc_tkeep = 2'b11;
      end else begin
        m_axis_cc_tdata = w_beat1;
        m_axis_cc_tkeep = w_ur ? 2'b01 : 2'b11;
        m_axis_cc_tlast = 1'b1;
      end
    end
  end

  assign m_axis_cc_tuser = '0;
  assign pcie_cq_np_req  = (r_state == StCpl1 && w_cc_hs) ? 2'b01 : 2'b00;
  assign stat_err_req    = w_err;

endmodule

// File: tb/tb_pcie_us_cq_cc_responder.sv
// Scoreboard bench: stimulus pushes expected CC beats, a negedge monitor pops and compares.
module tb_pcie_us_cq_cc_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] cq_tdata = '0;
  logic [1:0]  cq_tkeep = 2'b11;
  logic        cq_tlast = 1'b0;
  logic [87:0] cq_tuser = '0;
  logic        cq_tvalid = 1'b0;
  logic        cq_tready;
  logic [63:0] cc_tdata;
  logic [1:0]  cc_tkeep;
  logic        cc_tlast;
  logic [32:0] cc_tuser;
  logic        cc_tvalid;
  logic        cc_tready = 1'b1;
  logic [1:0]  np_req;
  logic [7:0]  bus = 8'h5A;
  logic        err_req;

  always #5 clk = ~clk;

  pcie_us_cq_cc_responder dut (
    .user_clk         (clk),
    .user_reset       (rst),
    .s_axis_cq_tdata  (cq_tdata),
    .s_axis_cq_tkeep  (cq_tkeep),
    .s_axis_cq_tlast  (cq_tlast),
    .s_axis_cq_tuser  (cq_tuser),
    .s_axis_cq_tvalid (cq_tvalid),
    .s_axis_cq_tready (cq_tready),
    .m_axis_cc_tdata  (cc_tdata),
    .m_axis_cc_tkeep  (cc_tkeep),
    .m_axis_cc_tlast  (cc_tlast),
    .m_axis_cc_tuser  (cc_tuser),
    .m_axis_cc_tvalid (cc_tvalid),
    .m_axis_cc_tready (cc_tready),
    .pcie_cq_np_req   (np_req),
    .cfg_bus_number   (bus),
    .stat_err_req     (err_req)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          err_cnt = 0;
  int          np_cnt = 0;
  int          exp_err = 0;
  int          exp_np = 0;
  logic [31:0] mdl [16];
  logic [15:0] g_reqid = 16'h1234;
  logic [7:0]  g_func = 8'h07;
  logic [2:0]  g_tc = 3'b101;
  logic [2:0]  g_attr = 3'b011;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (err_req === 1'b1) err_cnt++;
    if (np_req === 2'b01) np_cnt++;
    if (cc_tvalid === 1'b1 && cc_tready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL cc_unexpected_beat: got tdata %h with no beat expected", cc_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("cc_tdata", cc_tdata, e.d);
        chk("cc_tkeep", {62'b0, cc_tkeep}, {62'b0, e.k});
        chk("cc_tlast", {63'b0, cc_tlast}, {63'b0, e.l});
        chk("cc_tuser", {31'b0, cc_tuser}, 64'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] hdr1(input logic [3:0] typ, input logic [10:0] dw,
                                       input logic [7:0] tag);
    logic [63:0] h;
    h = '0;
    h[10:0]  = dw;
    h[14:11] = typ;
    h[31:16] = g_reqid;
    h[39:32] = tag;
    h[47:40] = g_func;
    h[59:57] = g_tc;
    h[62:60] = g_attr;
    return h;
  endfunction

  // Entered at posedge+1; leaves at posedge+1 after the beat is accepted.
  task automatic cq_beat(input logic [63:0] d, input logic last, input logic [3:0] be);
    int n;
    n = 0;
    cq_tdata  = d;
    cq_tlast  = last;
    cq_tuser  = {84'b0, be};
    cq_tvalid = 1'b1;
    @(negedge clk);
    while (!cq_tready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      n_chk++;
      $display("FAIL cq_tready_timeout: got tready 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    cq_tvalid = 1'b0;
    cq_tlast  = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
    logic [3:0] idx;
    idx = addr[5:2];
    cq_beat({addr[63:2], 2'b00}, 1'b0, be);
    cq_beat(hdr1(4'b0001, 11'd1, 8'h00), 1'b0, 4'h0);
    cq_beat({32'hA5A5_5A5A, data}, 1'b1, 4'h0);
    for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic push_read(input logic [63:0] addr, input logic [7:0] tag,
                           input logic [10:0] dw, input bit both);
    beat_t e;
    logic  ur;
    ur = (dw != 11'd1);
    e.d = {g_reqid, 2'b00, (ur ? 3'b001 : 3'b000), (ur ? 11'd0 : 11'd1), 3'b000, 13'd4,
           6'b0, 2'b00, 1'b0, addr[6:2], 2'b00};
    e.k = 2'b11;
    e.l = 1'b0;
    exp_q.push_back(e);
    if (both) begin
      e.d = {(ur ? 32'h0 : mdl[addr[5:2]]), 1'b0, g_attr, g_tc, 1'b1, bus, g_func, tag};
      e.k = ur ? 2'b01 : 2'b11;
      e.l = 1'b1;
      exp_q.push_back(e);
      exp_np++;
    end
    if (ur) exp_err++;
  endtask

  task automatic send_read(input logic [63:0] addr, input logic [7:0] tag,
                           input logic [10:0] dw, input int extra);
    cq_beat({addr[63:2], 2'b00}, 1'b0, 4'hF);
    cq_beat(hdr1(4'b0000, dw, tag), (extra == 0), 4'h0);
    for (int i = 0; i < extra; i++) cq_beat(64'hFFFF_0000_1111_2222, (i == extra - 1), 4'h0);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL %s: %0d CC beats still outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_stat_err"}, 64'(err_cnt), 64'(exp_err));
    chk({nm, "_np_req"}, 64'(np_cnt), 64'(exp_np));
  endtask

  task automatic wait_cc_valid(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (cc_tvalid !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      n_chk++;
      $display("FAIL %s: got tvalid 0 after %0d cycles, required 1", nm, n);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cq_tready", {63'b0, cq_tready}, 64'h0);
    chk("rst_cc_tvalid", {63'b0, cc_tvalid}, 64'h0);
    chk("rst_cc_tdata", cc_tdata, 64'h0);
    chk("rst_cc_tkeep_tlast", {61'b0, cc_tkeep, cc_tlast}, 64'h0);
    chk("rst_np_err", {61'b0, np_req, err_req}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cq_tready", {63'b0, cq_tready}, 64'h1);
    @(posedge clk);
    #1;

    // Full-word write then read back with tag 0x22.
    do_write(64'h14, 32'hDEAD_BEEF, 4'hF);
    push_read(64'h14, 8'h22, 11'd1, 1'b1);
    send_read(64'h14, 8'h22, 11'd1, 0);
    wait_drain("rd_0x14");
    chk_counts("rd_0x14");

    // Partial byte-enable write over all-ones.
    do_write(64'h0C, 32'hFFFF_FFFF, 4'hF);
    do_write(64'h0C, 32'h1122_3344, 4'b0101);
    chk("model_merge", {32'b0, mdl[3]}, 64'hFF22_FF44);
    push_read(64'h0C, 8'h33, 11'd1, 1'b1);
    send_read(64'h0C, 8'h33, 11'd1, 0);
    wait_drain("rd_be_merge");

    // Upper address bits ignored; lower address uses bit 6.
    g_reqid = 16'hBEEF; g_func = 8'h3C; g_tc = 3'b010; g_attr = 3'b100;
    do_write(64'h1000_0000_0000_0044, 32'hCAFE_F00D, 4'hF);
    push_read(64'h44, 8'h7E, 11'd1, 1'b1);
    send_read(64'h44, 8'h7E, 11'd1, 0);
    wait_drain("rd_hi_addr");
    push_read(64'h04, 8'h01, 11'd1, 1'b1);
    send_read(64'h04, 8'h01, 11'd1, 0);
    wait_drain("rd_alias_idx1");
    chk_counts("sc_reads");

    // Unsupported dword count: UR completion.
    push_read(64'h14, 8'h40, 11'd2, 1'b1);
    send_read(64'h14, 8'h40, 11'd2, 0);
    wait_drain("rd_ur");
    chk_counts("rd_ur");

    // Trailing beats dropped before the completion, SC then UR.
    push_read(64'h14, 8'h41, 11'd1, 1'b1);
    send_read(64'h14, 8'h41, 11'd1, 2);
    wait_drain("rd_drop_sc");
    push_read(64'h08, 8'h42, 11'd4, 1'b1);
    send_read(64'h08, 8'h42, 11'd4, 1);
    wait_drain("rd_drop_ur");
    chk_counts("rd_drop");

    // IO read: consumed silently apart from the error pulse.
    cq_beat(64'h20, 1'b0, 4'hF);
    cq_beat(hdr1(4'b0010, 11'd1, 8'h50), 1'b0, 4'h0);
    cq_beat(64'h0, 1'b1, 4'h0);
    exp_err++;
    repeat (4) @(posedge clk);
    #1;
    chk("io_cq_tready", {63'b0, cq_tready}, 64'h1);
    chk("io_cc_tvalid", {63'b0, cc_tvalid}, 64'h0);
    chk_counts("io_rd");

    // Single-beat packet is malformed.
    cq_beat(64'h20, 1'b1, 4'hF);
    exp_err++;
    repeat (2) @(posedge clk);
    #1;
    chk_counts("one_beat");

    // Backpressure on CPL0 for five cycles.
    cc_tready = 1'b0;
    push_read(64'h14, 8'h22, 11'd1, 1'b1);
    send_read(64'h14, 8'h22, 11'd1, 0);
    wait_cc_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_tvalid", {63'b0, cc_tvalid}, 64'h1);
      chk("bp_tdata", cc_tdata, exp_q[0].d);
      chk("bp_cq_tready", {63'b0, cq_tready}, 64'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cc_tready = 1'b1;
    wait_drain("bp_release");
    chk_counts("bp");

    // Reset during CPL1 aborts the completion and clears the register file.
    cc_tready = 1'b0;
    push_read(64'h14, 8'h23, 11'd1, 1'b0);
    send_read(64'h14, 8'h23, 11'd1, 0);
    wait_cc_valid("rst_cpl_valid");
    @(posedge clk);
    #1;
    cc_tready = 1'b1;
    @(posedge clk);
    #1;
    cc_tready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cpl1_tvalid", {63'b0, cc_tvalid}, 64'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cpl1_tvalid_next", {63'b0, cc_tvalid}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cc_tready = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    @(negedge clk);
    chk("rst_cpl1_cq_tready", {63'b0, cq_tready}, 64'h1);
    chk("rst_cpl1_no_resume", {63'b0, cc_tvalid}, 64'h0);
    @(posedge clk);
    #1;
    push_read(64'h14, 8'h24, 11'd1, 1'b1);
    send_read(64'h14, 8'h24, 11'd1, 0);
    wait_drain("rd_after_rst");
    push_read(64'h0C, 8'h25, 11'd1, 1'b1);
    send_read(64'h0C, 8'h25, 11'd1, 0);
    wait_drain("rd_after_rst_idx3");
    chk_counts("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
